uart_tx_queue: RTL

Byte queue and transmit pacer inserted between the UART receiver and the UART transmitter in the loopback path. It captures every received byte (rx_done pulse plus rx_data) into a FIFO. It then replays the bytes to the transmitter as single-cycle trigger pulses, spaced at least one full frame time apart, so that back-to-back received bytes are never lost or overwritten while the transmitter is still shifting. The transmitter exposes no busy flag, so pacing is by cycle count.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared timing helpers and pacer state encoding for the UART loopback path
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

  // Clock cycles per bit, truncated toward zero
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Clock cycles between successive transmit triggers
  function automatic int frame_cycles(input int clk_freq, input int baud, input int gap_bits);
    return bit_cycles(clk_freq, baud) * gap_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterised synchronous FIFO with registered count and flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_d;

  // A push while full is honoured only when a pop frees the head slot on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count;
    if (do_push && !do_pop) begin
      count_d = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; flags track the new count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue and frame-time pacer between UART receiver and transmitter
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 11,
  parameter int DEPTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_done,
  input  logic                        clear_ovf,
  output logic [7:0]                  tx_data,
  output logic                        tx_trigger_flag,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        overflow
);

  localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, BAUD, GAP_BITS);
  localparam int GW           = $clog2(FRAME_CYCLES);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_queue: DEPTH must be a power of two and at least 2");
  end
  if (FRAME_CYCLES < 3) begin : g_frame_check
    $error("uart_tx_queue: FRAME_CYCLES must be at least 3");
  end

  tx_state_e       state_q;
  tx_state_e       state_d;
  logic [GW-1:0]   gap_q;
  logic [GW-1:0]   gap_d;
  logic [7:0]      tx_data_d;
  logic [7:0]      fifo_head;
  logic            pop;
  logic            drop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_done),
    .push_data (rx_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pacer: take the head in IDLE, pulse in TRIG, then count out the rest of the frame.
  // The WAIT exit fires when the counter is about to reach zero so triggers land exactly
  // FRAME_CYCLES apart (TRIG + FRAME_CYCLES-2 WAIT cycles + IDLE).
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_data_d = tx_data;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_data_d = fifo_head;
          pop       = 1'b1;
          state_d   = TRIG;
        end
      end
      TRIG: begin
        gap_d   = GW'(FRAME_CYCLES - 2);
        state_d = WAIT;
      end
      WAIT: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pacer registers; the trigger is registered so it is glitch-free towards the transmitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gap_q           <= '0;
      tx_data         <= 8'h00;
      tx_trigger_flag <= 1'b0;
    end else begin
      state_q         <= state_d;
      gap_q           <= gap_d;
      tx_data         <= tx_data_d;
      tx_trigger_flag <= (state_q == TRIG);
    end
  end

  assign drop = rx_done && fifo_full && !pop;

  // Sticky overflow; a new drop beats a clear on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
